alu_seq: RTL and testbench

- Parametrised, registered successor to the combinational datapath ALU.
- Captures operands on a valid/ready handshake and computes shifts iteratively, SHIFT_STEP bits per cycle, which suits a TTL-style datapath with no barrel shifter.
- Adds SRA, SLT and SLTU, and registers the eq/lt/ltu compare flags for the branch unit.
- The held result drives the shared data bus and address bus through independent tristate enables.

---
 rtl/alu_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, iterative shifter and tristate result drive.
// Define ALU_SEQ_BARREL_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             alu_eq,
  output logic             alu_lt,
  output logic             alu_ltu,
  output logic             out_err,
  input  logic             bus_en,
  input  logic             addr_en,
  output logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] addr
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] STEP = SHW'(SHIFT_STEP);

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_XOR  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             ltu_q, ltu_d;
  logic             err_q, err_d;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [SHW-1:0]   k;
  logic             eq_c, lt_c, ltu_c;
  logic [WIDTH-1:0] op_res;
  logic             op_illegal;
  logic             op_shift;

  assign shamt = b[SHW-1:0];
  assign eq_c  = (a == b);
  assign lt_c  = ($signed(a) < $signed(b));
  assign ltu_c = (a < b);

  // Value loaded into result on the accept edge; iterative shifts start from a.
  always_comb begin
    op_res     = '0;
    op_illegal = 1'b0;
    op_shift   = 1'b0;
    case (op)
      OP_OR:   op_res = a | b;
      OP_XOR:  op_res = a ^ b;
      OP_AND:  op_res = a & b;
      OP_ADD:  op_res = a + b;
      OP_SUB:  op_res = a - b;
      OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, lt_c};
      OP_SLTU: op_res = {{(WIDTH-1){1'b0}}, ltu_c};
`ifdef ALU_SEQ_BARREL_EN
      OP_SLL: begin
        op_shift = 1'b1;
        op_res   = a << shamt;
      end
      OP_SRL: begin
        op_shift = 1'b1;
        op_res   = a >> shamt;
      end
      OP_SRA: begin
        op_shift = 1'b1;
        op_res   = $unsigned($signed(a) >>> shamt);
      end
`else
      OP_SLL, OP_SRL, OP_SRA: begin
        op_shift = 1'b1;
        op_res   = a;
      end
`endif
      default: op_illegal = 1'b1;
    endcase
  end

  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;
  assign k        = (cnt_q > STEP) ? STEP : cnt_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    ltu_d    = ltu_q;
    err_d    = err_q;
    case (state_q)
      SHIFT: begin
        case (op_q)
          OP_SLL:  result_d = result_q << k;
          OP_SRL:  result_d = result_q >> k;
          default: result_d = $unsigned($signed(result_q) >>> k);
        endcase
        cnt_d = cnt_q - k;
        if (cnt_q == k) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase
    // An accept overrides the HOLD->IDLE exit so back-to-back ops see no bubble.
    if (accept) begin
      op_d     = op;
      eq_d     = eq_c;
      lt_d     = lt_c;
      ltu_d    = ltu_c;
      err_d    = op_illegal;
      result_d = op_res;
      cnt_d    = '0;
      state_d  = HOLD;
`ifndef ALU_SEQ_BARREL_EN
      if (op_shift && (shamt != '0)) begin
        cnt_d   = shamt;
        state_d = SHIFT;
      end
`else
      if (op_shift) begin
        cnt_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      ltu_q    <= ltu_d;
      err_q    <= err_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign alu_eq    = eq_q;
  assign alu_lt    = lt_q;
  assign alu_ltu   = ltu_q;
  assign out_err   = err_q;

  assign bus  = bus_en  ? result_q : {WIDTH{1'bz}};
  assign addr = addr_en ? result_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a behavioural reference model.
module tb_alu_seq;

  localparam int W    = 32;
  localparam int STEP = 1;
  localparam int SHW  = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         alu_eq, alu_lt, alu_ltu, out_err;
  logic         bus_en = 1'b0;
  logic         addr_en = 1'b0;
  wire  [W-1:0] bus;
  wire  [W-1:0] addr;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         eq;
    logic         lt;
    logic         ltu;
    logic         err;
    int           lat;
  } exp_t;

  alu_seq #(.WIDTH(W), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .out_err(out_err), .bus_en(bus_en), .addr_en(addr_en), .bus(bus), .addr(addr)
  );

  always #5 clk = ~clk;

  // Reference model: result, flags and latency straight from the opcode definitions.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t m;
    int sh;
    sh    = int'(y[SHW-1:0]);
    m.eq  = (x == y);
    m.lt  = ($signed(x) < $signed(y));
    m.ltu = (x < y);
    m.err = 1'b0;
    m.lat = 1;
    m.res = '0;
    case (o)
      4'd0: m.res = x | y;
      4'd1: m.res = x ^ y;
      4'd2: m.res = x & y;
      4'd3: m.res = x << sh;
      4'd4: m.res = x >> sh;
      4'd5: m.res = x + y;
      4'd6: m.res = x - y;
      4'd7: begin
        m.res = x;
        for (int i = 0; i < sh; i++) m.res = {m.res[W-1], m.res[W-1:1]};
      end
      4'd8: m.res = m.lt ? 1 : 0;
      4'd9: m.res = m.ltu ? 1 : 0;
      default: m.err = 1'b1;
    endcase
`ifndef ALU_SEQ_BARREL_EN
    if (o == 4'd3 || o == 4'd4 || o == 4'd7) m.lat = 1 + (sh + STEP - 1) / STEP;
`endif
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkNotDriven(input string tag, input logic [W-1:0] obs, input logic [W-1:0] held);
    testsRun++;
    assert (obs !== held) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%h expected high-Z, not %h", tag, obs, held);
    end
  endtask

  // Issue one op from IDLE and wait (bounded) for out_valid; out_ready stays low.
  task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               output int lat, output logic sawReady);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom);
    a = $urandom;
    b = $urandom;
    lat = 1;
    sawReady = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) sawReady = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic checkResult(input string tag, input exp_t e, input int lat, input logic sawReady);
    checkOutput({tag, "_latency"}, W'(lat), W'(e.lat));
    checkOutput({tag, "_busy_ready"}, W'(sawReady), '0);
    checkOutput({tag, "_valid"}, W'(out_valid), 1);
    checkOutput({tag, "_result"}, result, e.res);
    checkOutput({tag, "_eq"}, W'(alu_eq), W'(e.eq));
    checkOutput({tag, "_lt"}, W'(alu_lt), W'(e.lt));
    checkOutput({tag, "_ltu"}, W'(alu_ltu), W'(e.ltu));
    checkOutput({tag, "_err"}, W'(out_err), W'(e.err));
  endtask

  task automatic releaseOutput(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_idle_valid"}, W'(out_valid), 0);
    checkOutput({tag, "_idle_ready"}, W'(in_ready), 1);
  endtask

  task automatic runOp(input string tag, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    logic sawReady;
    exp_t e;
    e = model(o, x, y);
    applyStimulus(o, x, y, lat, sawReady);
    checkResult(tag, e, lat, sawReady);
    releaseOutput(tag);
  endtask

  initial begin
    int lat;
    logic sawReady;
    logic sawValid;
    exp_t e;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_result", result, '0);
    checkOutput("rst_valid", W'(out_valid), 0);
    checkOutput("rst_ready", W'(in_ready), 1);
    checkOutput("rst_err", W'(out_err), 0);
    checkOutput("rst_flags", W'({alu_eq, alu_lt, alu_ltu}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Wrapping arithmetic and flags
    runOp("add_wrap", 4'd5, 32'hFFFF_FFFF, 32'h1);
    runOp("sub_neg", 4'd6, 32'd5, 32'd7);
    runOp("sra_31", 4'd7, 32'h8000_0000, 32'd31);
    runOp("srl_0", 4'd4, 32'hDEAD_BEEF, 32'd0);

    // Result held under backpressure, then back-to-back accept
    e = model(4'd9, 32'd1, 32'd2);
    applyStimulus(4'd9, 32'd1, 32'd2, lat, sawReady);
    checkResult("sltu_hold", e, lat, sawReady);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_result", result, 32'd1);
      checkOutput("hold_ready", W'(in_ready), 0);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = 4'd1;
    a = 32'hF0F0;
    b = 32'hFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("b2b_valid", W'(out_valid), 1);
    checkOutput("b2b_result", result, 32'h0F0F);
    releaseOutput("b2b");

    // Illegal opcode and its clearing
    runOp("illegal_12", 4'd12, 32'h55, 32'h55);
    e = model(4'd12, 32'h1, 32'h2);
    applyStimulus(4'd12, 32'h1, 32'h2, lat, sawReady);
    checkResult("illegal_hold", e, lat, sawReady);
    releaseOutput("illegal_hold");
    runOp("clear_err", 4'd2, 32'hFF00, 32'h0FF0);

    // Tristate drive of the held result
    runOp("or_1234", 4'd0, 32'h1230, 32'h0004);
    bus_en = 1'b1;
    addr_en = 1'b0;
    #1;
    checkOutput("bus_drive", bus, 32'h1234);
    checkNotDriven("addr_off", addr, 32'h1234);
    bus_en = 1'b0;
    addr_en = 1'b1;
    #1;
    checkOutput("addr_drive", addr, 32'h1234);
    checkNotDriven("bus_off", bus, 32'h1234);
    addr_en = 1'b0;
    #1;
    checkNotDriven("bus_both_off", bus, 32'h1234);
    checkNotDriven("addr_both_off", addr, 32'h1234);

    // Reset in the middle of a long shift discards the operation
    in_valid = 1'b1;
    op = 4'd3;
    a = 32'hA5A5_A5A5;
    b = 32'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", W'(out_valid), 0);
    checkOutput("midrst_result", result, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("midrst_ready", W'(in_ready), 1);
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("midrst_no_stale", W'(sawValid), 0);

    // Randomized ops against the model
    for (int n = 0; n < 24; n++) begin
      logic [3:0] ro;
      logic [W-1:0] ra, rb;
      ro = 4'($urandom_range(0, 11));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      runOp("random", ro, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
